// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
);
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic [DATA_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic [DATA_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache p0, D-cache p1) arbiter for a single data memory port.
// Default: fixed priority to p1. Define MEM_ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input logic            clk_i,
    input logic            rst_i,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              pick1;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last requester served by a completed (acked) grant; reset value 0 hands p1 the first tie.
    logic last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last <= 1'b0;
        end else if (state == GRANT0 && bus.mem_ack_i) begin
            last <= 1'b0;
        end else if (state == GRANT1 && bus.mem_ack_i) begin
            last <= 1'b1;
        end
    end

    assign pick1 = bus.p1_enable_i & (~bus.p0_enable_i | ~last);
`else
    assign pick1 = bus.p1_enable_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick1) begin
                    state_next = GRANT1;
                end else if (bus.p0_enable_i) begin
                    state_next = GRANT0;
                end
            end
            GRANT0: begin
                if (bus.mem_ack_i || !bus.p0_enable_i) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (bus.mem_ack_i || !bus.p1_enable_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from the registered state only, so async reset drops them at once.
    always_comb begin
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        addr_sel         = '0;
        wdata_sel        = '0;
        rdata0           = '0;
        rdata1           = '0;
        bus.p0_ack_o     = 1'b0;
        bus.p1_ack_o     = 1'b0;
        case (state)
            GRANT0: begin
                bus.mem_enable_o = bus.p0_enable_i;
                bus.mem_write_o  = bus.p0_write_i;
                addr_sel         = bus.p0_addr_i;
                wdata_sel        = bus.p0_data_i;
                rdata0           = bus.mem_data_i;
                bus.p0_ack_o     = bus.mem_ack_i;
            end
            GRANT1: begin
                bus.mem_enable_o = bus.p1_enable_i;
                bus.mem_write_o  = bus.p1_write_i;
                addr_sel         = bus.p1_addr_i;
                wdata_sel        = bus.p1_data_i;
                rdata1           = bus.mem_data_i;
                bus.p1_ack_o     = bus.mem_ack_i;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o = addr_sel;
    assign bus.mem_data_o = wdata_sel;
    assign bus.p0_data_o  = rdata0;
    assign bus.p1_data_o  = rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter in its default fixed-priority build.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later still.
module tb_mem_arbiter;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_b;
    logic [DATA_W-1:0] ones;

    mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pat_a  = {8{32'hA5A5_0001}};
        pat_b  = {8{32'h5A5A_0002}};
        ones   = '1;

        rst             = 1'b1;
        bus.p0_enable_i = 1'b1;
        bus.p0_write_i  = 1'b1;
        bus.p0_addr_i   = 32'h0000_0100;
        bus.p0_data_i   = pat_a;
        bus.p1_enable_i = 1'b1;
        bus.p1_write_i  = 1'b0;
        bus.p1_addr_i   = 32'h0000_0200;
        bus.p1_data_i   = pat_b;
        bus.mem_data_i  = pat_b;
        bus.mem_ack_i   = 1'b1;

        // Reset: everything zero even with requests and ack present
        step();
        step();
        check("rst_mem_en",   bus.mem_enable_o, 0);
        check("rst_mem_wr",   bus.mem_write_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_data", bus.mem_data_o, 0);
        check("rst_p0_ack",   bus.p0_ack_o, 0);
        check("rst_p1_ack",   bus.p1_ack_o, 0);
        check("rst_p0_data",  bus.p0_data_o, 0);
        check("rst_p1_data",  bus.p1_data_o, 0);

        bus.p0_enable_i = 1'b0;
        bus.p1_enable_i = 1'b0;
        bus.mem_ack_i   = 1'b0;
        bus.p0_write_i  = 1'b0;
        step();
        rst = 1'b0;
        step();

        // p1 read of 0x400, ack after 10 cycles
        bus.p1_enable_i = 1'b1;
        bus.p1_write_i  = 1'b0;
        bus.p1_addr_i   = 32'h0000_0400;
        #1;
        check("rd_idle_en", bus.mem_enable_o, 0);
        step();
        check("rd_grant_en",   bus.mem_enable_o, 1);
        check("rd_grant_addr", bus.mem_addr_o, 32'h400);
        check("rd_grant_wr",   bus.mem_write_o, 0);
        check("rd_p1_ack_lo",  bus.p1_ack_o, 0);
        check("rd_p0_data_lo", bus.p0_data_o, 0);
        check("rd_p1_data",    bus.p1_data_o, pat_b);
        repeat (9) step();
        check("rd_hold_en", bus.mem_enable_o, 1);
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = pat_a;
        #1;
        check("rd_p1_ack",  bus.p1_ack_o, 1);
        check("rd_p1_data_ack", bus.p1_data_o, pat_a);
        check("rd_p0_ack",  bus.p0_ack_o, 0);
        step();
        bus.mem_ack_i   = 1'b0;
        bus.p1_enable_i = 1'b0;
        #1;
        check("rd_done_en",  bus.mem_enable_o, 0);
        check("rd_done_ack", bus.p1_ack_o, 0);

        // Stray memory ack in IDLE is ignored
        bus.mem_ack_i = 1'b1;
        #1;
        check("idle_ack_p0", bus.p0_ack_o, 0);
        check("idle_ack_p1", bus.p1_ack_o, 0);
        step();
        bus.mem_ack_i = 1'b0;
        #1;
        check("idle_ack_stay", bus.mem_enable_o, 0);

        // Simultaneous requests: fixed priority grants p1, then p1 again on re-request
        bus.p0_enable_i = 1'b1;
        bus.p0_addr_i   = 32'h0000_0100;
        bus.p1_enable_i = 1'b1;
        bus.p1_addr_i   = 32'h0000_0200;
        step();
        check("tie1_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i = 1'b1;
        #1;
        check("tie1_p1_ack", bus.p1_ack_o, 1);
        check("tie1_p0_ack", bus.p0_ack_o, 0);
        step();
        bus.mem_ack_i = 1'b0;
        #1;
        check("tie_gap_en", bus.mem_enable_o, 0);
        step();
        check("tie2_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i = 1'b1;
        #1;
        check("tie2_p1_ack", bus.p1_ack_o, 1);
        step();
        bus.mem_ack_i   = 1'b0;
        bus.p1_enable_i = 1'b0;
        #1;
        check("tie2_gap_en", bus.mem_enable_o, 0);
        step();
        check("p0_grant_addr", bus.mem_addr_o, 32'h100);
        check("p0_grant_en",   bus.mem_enable_o, 1);

        // p1 asks mid-grant: no effect until p0 is acked, then one idle cycle
        bus.p1_enable_i = 1'b1;
        bus.p1_write_i  = 1'b1;
        bus.p1_addr_i   = 32'h0000_0300;
        bus.mem_data_i  = pat_b;
        #1;
        check("mid_addr",    bus.mem_addr_o, 32'h100);
        check("mid_wr",      bus.mem_write_o, 0);
        check("mid_p1_data", bus.p1_data_o, 0);
        check("mid_p0_data", bus.p0_data_o, pat_b);
        step();
        step();
        check("mid_hold_addr", bus.mem_addr_o, 32'h100);
        bus.mem_ack_i = 1'b1;
        #1;
        check("mid_p0_ack", bus.p0_ack_o, 1);
        check("mid_p1_ack", bus.p1_ack_o, 0);
        step();
        bus.mem_ack_i   = 1'b0;
        bus.p0_enable_i = 1'b0;
        #1;
        check("mid_gap_en", bus.mem_enable_o, 0);
        step();
        check("mid_p1_addr", bus.mem_addr_o, 32'h300);
        check("mid_p1_wr",   bus.mem_write_o, 1);

        // p1 aborts: enable follows combinationally, no ack
        bus.p1_enable_i = 1'b0;
        #1;
        check("p1_abort_en",  bus.mem_enable_o, 0);
        check("p1_abort_ack", bus.p1_ack_o, 0);
        step();

        // p1 write of all-ones to 0x20
        bus.p1_enable_i = 1'b1;
        bus.p1_write_i  = 1'b1;
        bus.p1_addr_i   = 32'h0000_0020;
        bus.p1_data_i   = ones;
        step();
        check("wr_en",   bus.mem_enable_o, 1);
        check("wr_wr",   bus.mem_write_o, 1);
        check("wr_addr", bus.mem_addr_o, 32'h20);
        check("wr_data", bus.mem_data_o, ones);
        check("wr_p0_ack_pre", bus.p0_ack_o, 0);
        bus.mem_ack_i = 1'b1;
        #1;
        check("wr_p1_ack", bus.p1_ack_o, 1);
        check("wr_p0_ack", bus.p0_ack_o, 0);
        step();
        bus.mem_ack_i   = 1'b0;
        bus.p1_enable_i = 1'b0;
        bus.p1_write_i  = 1'b0;
        #1;
        check("wr_done_ack", bus.p1_ack_o, 0);

        // Reset during GRANT0 drops enable at once; held request re-granted a cycle later
        bus.p0_enable_i = 1'b1;
        bus.p0_write_i  = 1'b0;
        bus.p0_addr_i   = 32'h0000_0040;
        step();
        check("rg_en", bus.mem_enable_o, 1);
        rst = 1'b1;
        #1;
        check("rg_async_en", bus.mem_enable_o, 0);
        check("rg_async_addr", bus.mem_addr_o, 0);
        step();
        rst = 1'b0;
        #1;
        check("rg_idle_en", bus.mem_enable_o, 0);
        step();
        check("rg_regrant_en",   bus.mem_enable_o, 1);
        check("rg_regrant_addr", bus.mem_addr_o, 32'h40);

        // p0 aborts in GRANT0: back to IDLE, no ack
        bus.p0_enable_i = 1'b0;
        #1;
        check("ab_en",     bus.mem_enable_o, 0);
        check("ab_p0_ack", bus.p0_ack_o, 0);
        check("ab_p1_ack", bus.p1_ack_o, 0);
        step();
        bus.p0_enable_i = 1'b1;
        #1;
        check("ab_idle_en", bus.mem_enable_o, 0);
        step();
        check("ab_regrant_en", bus.mem_enable_o, 1);
        bus.mem_ack_i = 1'b1;
        #1;
        check("ab_final_ack", bus.p0_ack_o, 1);
        step();
        bus.mem_ack_i   = 1'b0;
        bus.p0_enable_i = 1'b0;
        #1;
        check("end_idle_en", bus.mem_enable_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
